// File: rtl/can_tx_framer_if.sv
// can_tx_framer_if: message handshake and serial status of the CAN frame transmitter.
interface can_tx_framer_if #(parameter int DEPTH = 4);
    logic                   msg_valid;
    logic                   msg_ready;
    logic [10:0]            msg_id;
    logic                   msg_rtr;
    logic [3:0]             msg_dlc;
    logic [63:0]            msg_data;
    logic                   tx;
    logic                   busy;
    logic                   frame_done;
    logic [$clog2(DEPTH):0] fifo_count;

    modport master (
        output msg_valid, msg_id, msg_rtr, msg_dlc, msg_data,
        input  msg_ready, tx, busy, frame_done, fifo_count
    );
    modport slave (
        input  msg_valid, msg_id, msg_rtr, msg_dlc, msg_data,
        output msg_ready, tx, busy, frame_done, fifo_count
    );
endinterface

// File: rtl/can_tx_framer.sv
// can_tx_framer: queues standard CAN data/remote frames and serialises them with CRC-15,
// bit stuffing, recessive tail and intermission, one bit per clk_low edge.
module can_tx_framer #(
    parameter int DEPTH    = 4,
    parameter int STUFF_EN = 1,
    parameter int IFS_BITS = 3
) (
    input logic            clk_low,
    input logic            rst_n,
    can_tx_framer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [6:0] IFS_LAST = 7'(IFS_BITS - 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CRC, TAIL, IFS} state_t;

    state_t        state_q, state_d;
    logic [79:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic [79:0]   frm_q, frm_d;
    logic [14:0]   crc_q, crc_d;
    logic [6:0]    bit_q, bit_d;
    logic [2:0]    run_q, run_d;
    logic          last_q, last_d;
    logic          push, pop, stuff, active, dbit;
    logic [3:0]    nbytes;
    logic [18:0]   hdr;

    // frm_q holds {id, rtr, dlc, data} latched at pop
    assign push    = bus.msg_valid && (count_q < FULL);
    assign hdr     = {1'b0, frm_q[79:68], 2'b00, frm_q[67:64]};
    assign nbytes  = frm_q[68] ? 4'd0 : (frm_q[67] ? 4'd8 : frm_q[67:64]);
    assign active  = state_q inside {HDR, DATA, CRC};
    assign stuff   = (STUFF_EN != 0) && active && (run_q == 3'd5);
    assign count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    always_comb begin
        dbit = state_q == HDR  ? hdr[5'd18 - bit_q[4:0]] :
               state_q == DATA ? frm_q[6'd63 - bit_q[5:0]] : crc_q[4'd14 - bit_q[3:0]];
    end

    always_ff @(posedge clk_low) begin
        if (push) mem_q[wr_q] <= {bus.msg_id, bus.msg_rtr, bus.msg_dlc, bus.msg_data};
    end

    always_ff @(posedge clk_low or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            frm_q   <= '0;
            crc_q   <= '0;
            bit_q   <= '0;
            run_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            count_q <= count_d;
            frm_q   <= frm_d;
            crc_q   <= crc_d;
            bit_q   <= bit_d;
            run_q   <= run_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        run_d   = run_q;
        last_d  = last_q;
        crc_d   = crc_q;
        frm_d   = frm_q;
        pop     = 1'b0;
        // a stuff cycle holds the bit counter and restarts the run with the complement
        if (stuff) begin
            run_d  = 3'd1;
            last_d = ~last_q;
        end else if (active) begin
            run_d  = (dbit == last_q) ? run_q + 3'd1 : 3'd1;
            last_d = dbit;
            bit_d  = bit_q + 7'd1;
            if (state_q != CRC) crc_d = {crc_q[13:0], 1'b0} ^ ((dbit ^ crc_q[14]) ? 15'h4599 : 15'h0);
        end
        case (state_q)
            IDLE: pop = |count_q;
            HDR: if (!stuff && bit_q == 7'd18) begin
                state_d = (nbytes != 4'd0) ? DATA : CRC;
                bit_d   = '0;
            end
            DATA: if (!stuff && bit_q == {nbytes, 3'b000} - 7'd1) begin
                state_d = CRC;
                bit_d   = '0;
            end
            // bit 15 marks a stuff bit owed after the last CRC bit
            CRC: if (stuff ? bit_q == 7'd15 : (bit_q == 7'd14 && !(STUFF_EN != 0 && run_d == 3'd5))) begin
                state_d = TAIL;
                bit_d   = '0;
            end
            TAIL: begin
                bit_d   = bit_q + 7'd1;
                if (bit_q == 7'd9) begin
                    state_d = IFS;
                    bit_d   = '0;
                end
            end
            IFS: begin
                bit_d = bit_q + 7'd1;
                if (bit_q == IFS_LAST) begin
                    pop     = |count_q;
                    state_d = IDLE;
                    bit_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = HDR;
            frm_d   = mem_q[rd_q];
            crc_d   = '0;
            run_d   = '0;
            last_d  = 1'b0;
            bit_d   = '0;
        end
    end

    always_comb begin
        bus.tx         = active ? (stuff ? ~last_q : dbit) : 1'b1;
        bus.busy       = state_q != IDLE;
        bus.frame_done = (state_q == IFS) && (bit_q == IFS_LAST);
        bus.msg_ready  = count_q < FULL;
        bus.fifo_count = count_q;
    end
endmodule
